// File: rtl/tlul_reg_host_if.sv
// Register-access port and TL-UL bundles of tlul_reg_host, grouped for port connection.
// slave is the adapter's view, master is the initiator/device side.
interface tlul_reg_host_if;
  logic         req_i;
  logic         we_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic [3:0]   be_i;
  logic         gnt_o;
  logic         valid_o;
  logic [31:0]  rdata_o;
  logic         err_o;
  logic         timeout_o;
  logic [101:0] tl_o;
  logic [67:0]  tl_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, tl_i,
    output gnt_o, valid_o, rdata_o, err_o, timeout_o, tl_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, tl_i,
    input  gnt_o, valid_o, rdata_o, err_o, timeout_o, tl_o
  );
endinterface

// File: rtl/tlul_reg_host.sv
// Single-outstanding TL-UL host: turns req/gnt register accesses into A-channel
// requests, checks the D-channel response and bounds each access with a watchdog.
module tlul_reg_host #(
  parameter logic [7:0]  SourceId      = 8'h00,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned TimeoutW      = $clog2(TimeoutCycles + 1)
) (
  input logic            clk_i,
  input logic            rst_ni,
  tlul_reg_host_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    AREQ,
    DRSP
  } state_e;

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpPutFullData   = 3'd0;
  localparam logic [2:0] OpPutPartial    = 3'd1;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  state_e state, state_next;

  logic [2:0]          a_opcode;
  logic [1:0]          a_size;
  logic [7:0]          a_source;
  logic [31:0]         a_address;
  logic [3:0]          a_mask;
  logic [31:0]         a_data;
  logic [TimeoutW-1:0] cnt;
  logic                valid_q;
  logic                err_q;
  logic                timeout_q;
  logic [31:0]         rdata_q;

  logic       a_valid;
  logic       d_ready;
  logic       gnt;
  logic       expired;
  logic       finish_rsp;
  logic       finish_to;
  logic       is_read;

  logic       d_valid;
  logic [2:0] d_opcode;
  logic [7:0] d_source;
  logic [31:0] d_data;
  logic       d_error;
  logic       a_ready;
  logic       unused_d_fields;

  assign d_valid  = bus.tl_i[67];
  assign d_opcode = bus.tl_i[66:64];
  assign d_source = bus.tl_i[58:51];
  assign d_data   = bus.tl_i[49:18];
  assign d_error  = bus.tl_i[1];
  assign a_ready  = bus.tl_i[0];
  assign unused_d_fields = ^{bus.tl_i[63:59], bus.tl_i[50], bus.tl_i[17:2]};

  assign is_read = (a_opcode == OpGet);
  assign expired = (cnt >= TimeoutW'(TimeoutCycles - 1));

  always_comb begin
    state_next = state;
    gnt        = 1'b0;
    a_valid    = 1'b0;
    d_ready    = 1'b1;
    finish_rsp = 1'b0;
    finish_to  = 1'b0;
    unique case (state)
      IDLE: begin
        gnt = bus.req_i;
        if (bus.req_i) state_next = AREQ;
      end
      AREQ: begin
        a_valid = 1'b1;
        d_ready = 1'b0;
        // a handshake in the expiry cycle wins over the watchdog
        if (a_ready) begin
          state_next = DRSP;
        end else if (expired) begin
          state_next = IDLE;
          finish_to  = 1'b1;
        end
      end
      DRSP: begin
        if (d_valid) begin
          state_next = IDLE;
          finish_rsp = 1'b1;
        end else if (expired) begin
          state_next = IDLE;
          finish_to  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      a_opcode  <= '0;
      a_size    <= '0;
      a_source  <= '0;
      a_address <= '0;
      a_mask    <= '0;
      a_data    <= '0;
      cnt       <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state     <= state_next;
      valid_q   <= finish_rsp | finish_to;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;

      if (state == IDLE) begin
        cnt <= '0;
        if (bus.req_i) begin
          a_opcode  <= !bus.we_i ? OpGet :
                       (bus.be_i == 4'hF) ? OpPutFullData : OpPutPartial;
          a_size    <= 2'd2;
          a_source  <= SourceId;
          a_address <= {bus.addr_i[31:2], 2'b00};
          a_mask    <= (!bus.we_i && bus.be_i == 4'h0) ? 4'hF : bus.be_i;
          a_data    <= bus.we_i ? bus.wdata_i : '0;
        end
      end else begin
        cnt <= cnt + TimeoutW'(1);
      end

      if (finish_rsp) begin
        err_q <= d_error | (d_source != SourceId) |
                 (d_opcode != (is_read ? OpAccessAckData : OpAccessAck));
        if (is_read) rdata_q <= d_data;
      end else if (finish_to) begin
        err_q     <= 1'b1;
        timeout_q <= 1'b1;
        if (is_read) rdata_q <= '1;
      end
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.valid_o   = valid_q;
  assign bus.err_o     = err_q;
  assign bus.timeout_o = timeout_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.tl_o      = {a_valid, a_opcode, 3'b000, a_size, a_source,
                          a_address, a_mask, a_data, 16'h0000, d_ready};

endmodule

// File: tb/tb_tlul_reg_host.sv
// Randomised scoreboard bench for tlul_reg_host: the driver plays initiator and
// device, pushes the expected response, and a negedge monitor checks each valid_o.
module tb_tlul_reg_host;
  localparam int unsigned TC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlul_reg_host_if bus();

  tlul_reg_host #(
    .SourceId(8'h00),
    .TimeoutCycles(TC)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } resp_t;

  resp_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rdata = '0;

  logic        d_valid = 1'b0;
  logic        a_ready = 1'b0;
  logic        d_err = 1'b0;
  logic [2:0]  d_op = '0;
  logic [7:0]  d_src = '0;
  logic [31:0] d_data = '0;

  assign bus.tl_i = {d_valid, d_op, 3'b000, 2'd2, d_src, 1'b0, d_data, 16'h0000, d_err, a_ready};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    resp_t e;
    if (bus.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", bus.valid_o, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", bus.rdata_o, e.rdata);
        check("rsp_err", bus.err_o, e.err);
        check("rsp_timeout", bus.timeout_o, e.to);
      end
    end
  end

  // Cycle c counts from the first cycle in AREQ. The A handshake lands at
  // a_dly and the D handshake at a_dly+1+d_dly; the watchdog fires at the first
  // cycle >= TC-1 in which the awaited handshake is absent.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int unsigned a_dly, input int unsigned d_dly,
                         input logic [2:0] op, input logic [7:0] src, input logic err,
                         input logic [31:0] data, input bit late_d);
    logic [2:0]   x_op;
    logic [3:0]   x_mask;
    logic [100:0] x_a;
    int unsigned  f, dc, lim, e;
    bit           done;
    resp_t        r;

    x_op   = !we ? 3'd4 : (be == 4'hF ? 3'd0 : 3'd1);
    x_mask = (!we && be == 4'h0) ? 4'hF : be;
    x_a    = {1'b1, x_op, 3'b000, 2'd2, 8'h00, addr[31:2], 2'b00, x_mask,
              (we ? wdata : 32'h0), 16'h0000};
    f   = a_dly + 1;
    dc  = f + d_dly;
    lim = (TC - 1 > f) ? TC - 1 : f;
    if (a_dly > TC - 1) begin
      done = 1'b0; e = TC - 1;
    end else if (dc <= lim) begin
      done = 1'b1; e = dc;
    end else begin
      done = 1'b0; e = lim;
    end

    r.to = !done;
    if (done) begin
      r.err = err || (src != 8'h00) || (op != (we ? 3'd0 : 3'd1));
      if (!we) model_rdata = data;
    end else begin
      r.err = 1'b1;
      if (!we) model_rdata = 32'hFFFF_FFFF;
    end
    r.rdata = model_rdata;
    exp_q.push_back(r);

    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wdata; bus.be_i = be;
    d_op = op; d_src = src; d_err = err;
    #1;
    check("gnt_idle", bus.gnt_o, 1'b1);
    @(negedge clk);

    for (int unsigned c = 0; c <= e; c++) begin
      check("gnt_busy", bus.gnt_o, 1'b0);
      if (c <= a_dly) begin
        check("a_chan", bus.tl_o[101:1], x_a);
        check("d_ready_areq", bus.tl_o[0], 1'b0);
        a_ready = (c == a_dly);
        d_valid = 1'b0;
      end else begin
        check("a_valid_drsp", bus.tl_o[101], 1'b0);
        check("d_ready_drsp", bus.tl_o[0], 1'b1);
        a_ready = 1'b0;
        d_valid = (c == dc);
      end
      d_data = d_valid ? data : $urandom;
      // inputs wander while busy; the captured A fields must not follow them
      bus.req_i = 1'($urandom); bus.we_i = 1'($urandom); bus.addr_i = $urandom;
      bus.wdata_i = $urandom; bus.be_i = 4'($urandom);
      @(negedge clk);
    end

    a_ready = 1'b0; d_valid = 1'b0; bus.req_i = 1'b0;
    check("valid_pulse", bus.valid_o, 1'b1);
    check("d_ready_idle", bus.tl_o[0], 1'b1);
    if (late_d) begin
      d_valid = 1'b1; d_data = $urandom;
      @(negedge clk);
      d_valid = 1'b0;
      check("late_d_discard", bus.valid_o, 1'b0);
    end
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      d_valid = 1'($urandom);
      d_data  = $urandom;
      @(negedge clk);
    end
    d_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid", bus.valid_o, 1'b0);
    check("rst_err", bus.err_o, 1'b0);
    check("rst_timeout", bus.timeout_o, 1'b0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_gnt", bus.gnt_o, 1'b0);
    check("rst_tl_o", bus.tl_o, 102'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-wait read, low address bits and empty mask
    run_txn(1'b0, 32'h0000_0013, 32'h0, 4'h0, 0, 0, 3'd1, 8'h00, 1'b0, 32'hCAFE_0001, 1'b0);
    idle_cycles(2);
    // partial write with a_ready held low three cycles
    run_txn(1'b1, 32'h0000_0104, 32'h1234_5678, 4'h3, 3, 0, 3'd0, 8'h00, 1'b0, 32'h0, 1'b0);
    // error responses: d_error, wrong source, AccessAck for a read
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 0, 1, 3'd1, 8'h00, 1'b1, 32'h1111_2222, 1'b0);
    run_txn(1'b1, 32'h0000_0024, 32'hAAAA_5555, 4'hF, 1, 0, 3'd0, 8'h05, 1'b0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h0000_0028, 32'h0, 4'hF, 0, 0, 3'd0, 8'h00, 1'b0, 32'h3333_4444, 1'b0);
    // device never answers, then a late response, then a normal read
    run_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 0, 100, 3'd1, 8'h00, 1'b0, 32'h5555_6666, 1'b1);
    run_txn(1'b0, 32'h0000_0034, 32'h0, 4'hF, 0, 0, 3'd1, 8'h00, 1'b0, 32'h7777_8888, 1'b0);
    // handshakes landing exactly on the expiry cycle
    run_txn(1'b0, 32'h0000_0038, 32'h0, 4'hF, TC - 1, 0, 3'd1, 8'h00, 1'b0, 32'h9999_0000, 1'b0);
    run_txn(1'b0, 32'h0000_003C, 32'h0, 4'hF, 0, TC - 2, 3'd1, 8'h00, 1'b0, 32'hABCD_EF01, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic       we;
      logic [2:0] op;
      we = 1'($urandom);
      op = we ? 3'd0 : 3'd1;
      if ($urandom_range(0, 7) == 0) op = ($urandom_range(0, 1) == 0) ? 3'd2 : ~op & 3'd1;
      run_txn(we, $urandom, $urandom, 4'($urandom), $urandom_range(0, 9), $urandom_range(0, 8),
              op, ($urandom_range(0, 7) == 0) ? 8'h05 : 8'h00, ($urandom_range(0, 7) == 0),
              $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

    // reset while a response is arriving in DRSP
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h40; bus.be_i = 4'hF;
    @(negedge clk);
    bus.req_i = 1'b0; a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0; d_valid = 1'b1; d_op = 3'd1; d_src = 8'h00; d_err = 1'b0;
    d_data = 32'hDEAD_BEEF; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tl_o", bus.tl_o, 102'h1);
    check("midrst_valid", bus.valid_o, 1'b0);
    check("midrst_rdata", bus.rdata_o, 32'h0);
    rst_n = 1'b1;
    model_rdata = '0;
    @(negedge clk);
    d_valid = 1'b0;
    check("postrst_valid", bus.valid_o, 1'b0);
    run_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 3'd1, 8'h00, 1'b0, 32'h0BAD_F00D, 1'b0);

    idle_cycles(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
